duration_quantizer: RTL and testbench
=====================================

// Module: duration_quantizer
// PURPOSE
//  Successor to the fixed-tempo duration detector: converts the per-sample tone-index stream into
//  quantized (tone, duration, rest) events. Tempo is a runtime input, with an internal sequential
//  divider. A glitch filter suppresses short tone flickers. Sixteenths and (optionally) dotted
//  values are detected. Events leave through a 2-entry valid/ready FIFO to the notation writer.
// PARAMETERS
//  SAMPLE_RATE  17000  tone_valid_in strobes per second
//  TONE_W       6      tone index width; index 0 = rest
//  BPM_W        8      width of bpm_in
//  CNT_W        24     run counter / quarter-length width
//  GLITCH_LEN   4      consecutive samples a new tone needs before commit (>=1)
// PORTS
//  clk_in            in   1       system clock
//  rst_in            in   1       synchronous, active-high reset
//  bpm_in            in   BPM_W   tempo; 0 treated as 1
//  tone_in           in   TONE_W  detected tone index
//  tone_valid_in     in   1       one-cycle strobe: tone_in is a new sample
//  event_valid_out   out  1       FIFO head valid
//  event_ready_in    in   1       consumer accepts head when valid&ready
//  event_tone_out    out  TONE_W  tone of finished run (0 = rest)
//  event_dur_out     out  4       1=16th 2=8th 3=qtr 4=half 5=whole 6=dot8th 7=dotqtr 8=dothalf
//  event_rest_out    out  1       event_tone_out==0
//  calc_busy_out     out  1       divider running; samples ignored
//  overflow_out      out  1       sticky: an event was dropped due to full FIFO
// BEHAVIOUR
//  Reset: all outputs 0 except calc_busy_out=1; cur_tone=0, run_cnt=0, cand_cnt=0, FIFO empty,
//   FSM->CALC latching bpm_in. Reset mid-division or mid-run discards everything.
//  FSM CALC: restoring division Q=(SAMPLE_RATE*60)/max(bpm_in,1), 1 quotient bit/cycle, CNT_W
//   cycles, then RUN. calc_busy_out=1 throughout CALC; tone_valid_in ignored.
//  FSM RUN: on any cycle bpm_in != latched bpm -> CALC; run_cnt and cur_tone kept, Q replaced.
//  Thresholds derived from Q by shifts/adds only: Q/4, Q/2, 3Q/4, Q, 3Q/2, 2Q, 3Q, 4Q.
//  Sample handling (RUN, tone_valid_in=1):
//   - run_cnt += 1, saturating at 2^CNT_W-1 (saturated run classifies as whole).
//   - tone_in==cur_tone: cand_cnt<=0 (pending flicker absorbed into current run).
//   - tone_in!=cur_tone, ==cand: cand_cnt+1; else cand<=tone_in, cand_cnt<=1.
//   - commit when the count including this sample reaches GLITCH_LEN: L=run_cnt_before-(GLITCH_LEN-1)
//     +... i.e. L = samples of old run excluding candidate samples; emit (cur_tone, L);
//     cur_tone<=tone_in; run_cnt<=GLITCH_LEN; cand_cnt<=0.
//  Classification of L, first match wins: >=4Q whole; >=2Q half; >=Q qtr; >=Q/2 8th; >=Q/4 16th;
//   else no event (silently dropped, overflow untouched).
//  Latency: event visible on event_valid_out the cycle after the committing sample if FIFO was empty.
//  FIFO: 2 entries, first-word fall-through. Push and pop in same cycle both succeed, even when full.
//   Push when full and no pop: event dropped, overflow_out<=1 (cleared only by reset).
//  Comparisons done at CNT_W+2 bits so 4Q never wraps.
// CONFIGURATION
//  DOTTED_QUANT_EN defined: dotted tiers inserted into the classification chain:
//   >=4Q whole; >=3Q dothalf(8); >=2Q half; >=3Q/2 dotqtr(7); >=Q qtr; >=3Q/4 dot8th(6); >=Q/2 8th; >=Q/4 16th.
//  Undefined: codes 6-8 never produced; dotted comparators not synthesised.
// TESTING (SAMPLE_RATE=64, GLITCH_LEN=4, bpm_in=60 -> Q=64; tone strobe every 4 clk)
//  Reset, wait CNT_W cycles -> calc_busy_out 1->0; no event; overflow_out=0.
//  70 samples tone 5, then 4 samples tone 9 -> event {5, dur=3, rest=0} (L=70).
//  40 samples tone 0, then tone 7 -> event {0, dur=2, rest=1}; 16th: 20 samples -> dur=1; 10 samples -> none.
//  Tone 5 run with 3-sample burst of tone 9 mid-run -> no event at burst; burst counted in run 5.
//  event_ready_in=0; complete 3 runs -> 2 events held, third dropped, overflow_out=1 sticky.
//  DOTTED_QUANT_EN: 100 samples -> dur=7; without macro, same stimulus -> dur=3.
//  Change bpm_in to 120 mid-run -> calc_busy_out pulses CNT_W cycles; Q=32; run continues.

Source files
------------

// File: rtl/duration_quantizer.sv
// duration_quantizer: converts the per-sample tone-index stream into quantized
// (tone, duration, rest) events. The quarter length Q is derived from bpm_in by an
// internal restoring divider. Events leave through a 2-entry FWFT valid/ready FIFO.
// Optional feature macro: DOTTED_QUANT_EN (adds dotted 8th/quarter/half codes 6-8).
module duration_quantizer #(
  parameter int unsigned SAMPLE_RATE = 17000,
  parameter int unsigned TONE_W      = 6,
  parameter int unsigned BPM_W       = 8,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned GLITCH_LEN  = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [BPM_W-1:0]  bpm_in,
  input  logic [TONE_W-1:0] tone_in,
  input  logic              tone_valid_in,
  output logic              event_valid_out,
  input  logic              event_ready_in,
  output logic [TONE_W-1:0] event_tone_out,
  output logic [3:0]        event_dur_out,
  output logic              event_rest_out,
  output logic              calc_busy_out,
  output logic              overflow_out
);

  typedef enum logic {ST_CALC = 1'b0, ST_RUN = 1'b1} state_t;

  localparam int unsigned DC_W = $clog2(CNT_W + 1);
  localparam int unsigned CC_W = $clog2(GLITCH_LEN + 1);
  localparam int unsigned TH_W = CNT_W + 2;
  localparam int unsigned EV_W = TONE_W + 4;

  localparam logic [CNT_W-1:0] DIVIDEND     = CNT_W'(SAMPLE_RATE * 60);
  localparam logic [DC_W-1:0]  DIV_LAST     = DC_W'(CNT_W - 1);
  localparam logic [CNT_W-1:0] RUN_MAX      = '1;
  localparam logic [CNT_W-1:0] RUN_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_START    = CNT_W'(GLITCH_LEN);
  localparam logic [CNT_W-1:0] CAND_BACKOUT = CNT_W'(GLITCH_LEN - 1);
  localparam logic [CC_W-1:0]  CAND_COMMIT  = CC_W'(GLITCH_LEN);
  localparam logic [CC_W-1:0]  CAND_ONE     = CC_W'(1);

  localparam logic [3:0] DUR_NONE  = 4'd0;
  localparam logic [3:0] DUR_16TH  = 4'd1;
  localparam logic [3:0] DUR_8TH   = 4'd2;
  localparam logic [3:0] DUR_QTR   = 4'd3;
  localparam logic [3:0] DUR_HALF  = 4'd4;
  localparam logic [3:0] DUR_WHOLE = 4'd5;
`ifdef DOTTED_QUANT_EN
  localparam logic [3:0] DUR_D8TH  = 4'd6;
  localparam logic [3:0] DUR_DQTR  = 4'd7;
  localparam logic [3:0] DUR_DHALF = 4'd8;
`endif

  // Tempo / divider state
  state_t            state_q;
  logic [BPM_W-1:0]  bpm_q;
  logic [CNT_W-1:0]  dvd_q;
  logic [BPM_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  quo_q, quo_d;
  logic [DC_W-1:0]   div_cnt_q;
  logic [CNT_W-1:0]  q_q;
  logic [BPM_W-1:0]  divisor;
  logic [BPM_W:0]    trial, diff;

  // Run tracking
  logic [TONE_W-1:0] cur_tone_q, cur_tone_d;
  logic [TONE_W-1:0] cand_q, cand_d;
  logic [CC_W-1:0]   cand_cnt_q, cand_cnt_d;
  logic [CC_W-1:0]   cand_next_cnt;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]  run_inc, run_len;
  logic              sample_en, same_tone, commit, run_sat;

  // Classification
  logic [TH_W-1:0]   q_ext, len_ext, thr_16, thr_8, thr_h, thr_w;
`ifdef DOTTED_QUANT_EN
  logic [TH_W-1:0]   thr_d8, thr_dq, thr_dh;
`endif
  logic [3:0]        dur;
  logic              push;

  // Event FIFO
  logic [1:0][EV_W-1:0] mem_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;
  logic              overflow_q;
  logic              full, pop, do_push;
  logic [EV_W-1:0]   head;

  always_comb begin
    divisor = (bpm_q == '0) ? BPM_W'(1) : bpm_q;
    trial   = {rem_q, dvd_q[CNT_W-1]};
    diff    = trial - {1'b0, divisor};
    if (trial >= {1'b0, divisor}) begin
      rem_d = diff[BPM_W-1:0];
      quo_d = {quo_q[CNT_W-2:0], 1'b1};
    end else begin
      rem_d = trial[BPM_W-1:0];
      quo_d = {quo_q[CNT_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_CALC;
      bpm_q     <= bpm_in;
      dvd_q     <= DIVIDEND;
      rem_q     <= '0;
      quo_q     <= '0;
      div_cnt_q <= '0;
      q_q       <= '0;
    end else begin
      case (state_q)
        ST_CALC: begin
          dvd_q     <= dvd_q << 1;
          rem_q     <= rem_d;
          quo_q     <= quo_d;
          div_cnt_q <= div_cnt_q + DC_W'(1);
          if (div_cnt_q == DIV_LAST) begin
            state_q <= ST_RUN;
            q_q     <= quo_d;
          end
        end
        ST_RUN: begin
          if (bpm_in != bpm_q) begin
            state_q   <= ST_CALC;
            bpm_q     <= bpm_in;
            dvd_q     <= DIVIDEND;
            rem_q     <= '0;
            quo_q     <= '0;
            div_cnt_q <= '0;
          end
        end
        default: state_q <= ST_CALC;
      endcase
    end
  end

  always_comb begin
    sample_en     = (state_q == ST_RUN) && tone_valid_in;
    same_tone     = (tone_in == cur_tone_q);
    cand_next_cnt = (tone_in == cand_q) ? (cand_cnt_q + CAND_ONE) : CAND_ONE;
    commit        = sample_en && !same_tone && (cand_next_cnt >= CAND_COMMIT);
    run_sat       = (run_cnt_q == RUN_MAX);
    run_inc       = run_sat ? run_cnt_q : (run_cnt_q + RUN_ONE);
    // run_cnt already includes the GLITCH_LEN-1 pending candidate samples; back them out
    run_len       = run_cnt_q - CAND_BACKOUT;

    cur_tone_d = cur_tone_q;
    cand_d     = cand_q;
    cand_cnt_d = cand_cnt_q;
    run_cnt_d  = run_cnt_q;
    if (sample_en) begin
      if (same_tone) begin
        run_cnt_d  = run_inc;
        cand_cnt_d = '0;
      end else if (commit) begin
        cur_tone_d = tone_in;
        cand_d     = tone_in;
        cand_cnt_d = '0;
        run_cnt_d  = RUN_START;
      end else begin
        run_cnt_d  = run_inc;
        cand_d     = tone_in;
        cand_cnt_d = cand_next_cnt;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cur_tone_q <= '0;
      cand_q     <= '0;
      cand_cnt_q <= '0;
      run_cnt_q  <= '0;
    end else begin
      cur_tone_q <= cur_tone_d;
      cand_q     <= cand_d;
      cand_cnt_q <= cand_cnt_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  always_comb begin
    q_ext   = {2'b00, q_q};
    len_ext = {2'b00, run_len};
    thr_16  = q_ext >> 2;
    thr_8   = q_ext >> 1;
    thr_h   = q_ext << 1;
    thr_w   = q_ext << 2;
`ifdef DOTTED_QUANT_EN
    thr_d8  = thr_8 + thr_16;
    thr_dq  = q_ext + thr_8;
    thr_dh  = thr_h + q_ext;
`endif
    dur = DUR_NONE;
    if (run_sat || (len_ext >= thr_w)) dur = DUR_WHOLE;
`ifdef DOTTED_QUANT_EN
    else if (len_ext >= thr_dh) dur = DUR_DHALF;
`endif
    else if (len_ext >= thr_h)  dur = DUR_HALF;
`ifdef DOTTED_QUANT_EN
    else if (len_ext >= thr_dq) dur = DUR_DQTR;
`endif
    else if (len_ext >= q_ext)  dur = DUR_QTR;
`ifdef DOTTED_QUANT_EN
    else if (len_ext >= thr_d8) dur = DUR_D8TH;
`endif
    else if (len_ext >= thr_8)  dur = DUR_8TH;
    else if (len_ext >= thr_16) dur = DUR_16TH;
    push = commit && (dur != DUR_NONE);
  end

  always_comb begin
    full    = (count_q == 2'd2);
    pop     = (count_q != 2'd0) && event_ready_in;
    // when full, a simultaneous pop frees the head slot, which is also the write slot
    do_push = push && (!full || pop);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= {cur_tone_q, dur};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    head            = mem_q[rd_ptr_q];
    event_valid_out = (count_q != 2'd0);
    event_tone_out  = event_valid_out ? head[EV_W-1:4] : '0;
    event_dur_out   = event_valid_out ? head[3:0] : '0;
    event_rest_out  = event_valid_out && (head[EV_W-1:4] == '0);
    calc_busy_out   = (state_q == ST_CALC);
    overflow_out    = overflow_q;
  end

endmodule

// File: tb/tb_duration_quantizer.sv
// Self-checking bench for duration_quantizer (SAMPLE_RATE=64, GLITCH_LEN=4).
// Stimulus is generated as whole runs; expected events come from run lengths.
module tb_duration_quantizer;

  localparam int unsigned SR = 64;
  localparam int unsigned TW = 6;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 24;
  localparam int unsigned GL = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [BW-1:0] bpm_in;
  logic [TW-1:0] tone_in;
  logic          tone_valid_in;
  logic          event_valid_out;
  logic          event_ready_in;
  logic [TW-1:0] event_tone_out;
  logic [3:0]    event_dur_out;
  logic          event_rest_out;
  logic          calc_busy_out;
  logic          overflow_out;

  always #5 clk_in = ~clk_in;

  duration_quantizer #(
    .SAMPLE_RATE(SR),
    .TONE_W(TW),
    .BPM_W(BW),
    .CNT_W(CW),
    .GLITCH_LEN(GL)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bpm_in(bpm_in),
    .tone_in(tone_in),
    .tone_valid_in(tone_valid_in),
    .event_valid_out(event_valid_out),
    .event_ready_in(event_ready_in),
    .event_tone_out(event_tone_out),
    .event_dur_out(event_dur_out),
    .event_rest_out(event_rest_out),
    .calc_busy_out(calc_busy_out),
    .overflow_out(overflow_out)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: FIFO contents {tone, dur}, sticky overflow, open run and tempo
  logic [TW+3:0] expq[$];
  logic          exp_ov;
  logic [TW-1:0] p_tone;
  int unsigned   p_len;
  int unsigned   q_model;
  logic          chk_lat;
  logic          rnd_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] classify(input int unsigned len, input int unsigned q);
    if (len >= 4 * q) return 4'd5;
`ifdef DOTTED_QUANT_EN
    if (len >= 3 * q) return 4'd8;
`endif
    if (len >= 2 * q) return 4'd4;
`ifdef DOTTED_QUANT_EN
    if (2 * len >= 3 * q) return 4'd7;
`endif
    if (len >= q) return 4'd3;
`ifdef DOTTED_QUANT_EN
    if (4 * len >= 3 * q) return 4'd6;
`endif
    if (len >= q / 2) return 4'd2;
    if (len >= q / 4) return 4'd1;
    return 4'd0;
  endfunction

  // One clock: drive, observe at negedge (consumer side), advance past posedge
  task automatic step(input logic v, input logic [TW-1:0] t);
    tone_valid_in = v;
    tone_in       = t;
    if (rnd_ready) event_ready_in = ($urandom_range(0, 3) != 0);
    @(negedge clk_in);
    if (chk_lat) begin
      chk("latency_valid", {31'd0, event_valid_out}, 32'd1);
      chk_lat = 1'b0;
    end
    if (event_valid_out && event_ready_in) begin
      chk("event_expected", {31'd0, expq.size() != 0}, 32'd1);
      if (expq.size() != 0) begin
        chk("event_tone", {26'd0, event_tone_out}, {26'd0, expq[0][TW+3:4]});
        chk("event_dur", {28'd0, event_dur_out}, {28'd0, expq[0][3:0]});
        chk("event_rest", {31'd0, event_rest_out}, {31'd0, expq[0][TW+3:4] == '0});
        void'(expq.pop_front());
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  // Run of n samples of tone t, optional burst of blen samples of bt at bpos
  task automatic send_segment(input logic [TW-1:0] t, input int unsigned n,
                              input int unsigned bpos, input int unsigned blen,
                              input logic [TW-1:0] bt);
    logic          merge;
    logic [TW-1:0] s;
    logic [3:0]    d;
    merge = (t == p_tone);
    for (int unsigned i = 0; i < n; i++) begin
      s = (blen != 0 && i >= bpos && i < bpos + blen) ? bt : t;
      step(1'b1, s);
      if (!merge && i == GL - 1) begin
        d = classify(p_len, q_model);
        if (d != 4'd0) begin
          if (expq.size() < 2) begin
            expq.push_back({p_tone, d});
            chk_lat = 1'b1;
          end else begin
            exp_ov = 1'b1;
          end
        end
        p_tone = t;
        p_len  = n;
      end
      step(1'b0, s);
      step(1'b0, s);
      step(1'b0, s);
    end
    if (merge) p_len += n;
    chk("overflow", {31'd0, overflow_out}, {31'd0, exp_ov});
  endtask

  task automatic set_bpm(input logic [BW-1:0] b);
    int unsigned n;
    logic        rr, rdy;
    rr = rnd_ready;
    rdy = event_ready_in;
    rnd_ready = 1'b0;
    event_ready_in = 1'b0;
    bpm_in = b;
    @(posedge clk_in);
    #1;
    chk("busy_rise", {31'd0, calc_busy_out}, 32'd1);
    n = 0;
    while (calc_busy_out === 1'b1 && n < 200) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    chk("busy_len", n, CW);
    q_model = (SR * 60) / ((b == 0) ? 1 : int'(b));
    rnd_ready = rr;
    event_ready_in = rdy;
  endtask

  task automatic do_reset(input logic [BW-1:0] b);
    int unsigned n;
    rst_in = 1'b1;
    bpm_in = b;
    tone_valid_in = 1'b0;
    event_ready_in = 1'b0;
    @(posedge clk_in);
    #1;
    @(posedge clk_in);
    #1;
    chk("rst_busy", {31'd0, calc_busy_out}, 32'd1);
    chk("rst_valid", {31'd0, event_valid_out}, 32'd0);
    chk("rst_overflow", {31'd0, overflow_out}, 32'd0);
    chk("rst_tone", {26'd0, event_tone_out}, 32'd0);
    chk("rst_dur", {28'd0, event_dur_out}, 32'd0);
    chk("rst_rest", {31'd0, event_rest_out}, 32'd0);
    rst_in = 1'b0;
    n = 0;
    while (calc_busy_out === 1'b1 && n < 200) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    chk("init_calc_len", n, CW);
    chk("init_no_event", {31'd0, event_valid_out}, 32'd0);
    expq.delete();
    exp_ov  = 1'b0;
    p_tone  = '0;
    p_len   = 0;
    q_model = (SR * 60) / ((b == 0) ? 1 : int'(b));
  endtask

  initial begin
    logic [BW-1:0] bpms [4];
    logic [BW-1:0] nb;
    logic [TW-1:0] t, bt;
    int unsigned   n, bpos, blen;

    bpms[0] = 8'd30; bpms[1] = 8'd60; bpms[2] = 8'd120; bpms[3] = 8'd240;
    rst_in = 1'b1; bpm_in = 8'd60; tone_in = '0; tone_valid_in = 1'b0;
    event_ready_in = 1'b0; chk_lat = 1'b0; rnd_ready = 1'b0;

    do_reset(8'd60);

    // Quarter note held in the FIFO, visible one cycle after commit
    send_segment(6'd5, 70, 0, 0, '0);
    send_segment(6'd9, 4, 0, 0, '0);
    chk("held_valid", {31'd0, event_valid_out}, 32'd1);
    chk("held_tone", {26'd0, event_tone_out}, 32'd5);
    chk("held_dur", {28'd0, event_dur_out}, 32'd3);
    chk("held_rest", {31'd0, event_rest_out}, 32'd0);
    event_ready_in = 1'b1;
    step(1'b0, 6'd9);
    chk("drained_1", {31'd0, event_valid_out}, 32'd0);

    // Rest eighth, sixteenth, too-short run dropped
    send_segment(6'd0, 40, 0, 0, '0);
    send_segment(6'd7, 20, 0, 0, '0);
    send_segment(6'd3, 10, 0, 0, '0);
    send_segment(6'd2, 40, 0, 0, '0);

    // Sub-threshold burst absorbed into the surrounding run
    send_segment(6'd5, 80, 30, 3, 6'd9);
    send_segment(6'd2, 40, 0, 0, '0);

    // Backpressure: two held, third dropped, overflow sticky
    event_ready_in = 1'b0;
    send_segment(6'd4, 70, 0, 0, '0);
    send_segment(6'd6, 70, 0, 0, '0);
    send_segment(6'd8, 4, 0, 0, '0);
    chk("ovf_set", {31'd0, overflow_out}, 32'd1);
    event_ready_in = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, 6'd8);
    chk("ovf_drained", {31'd0, event_valid_out}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow_out}, 32'd1);

    // 100 samples: dotted quarter or quarter depending on build
    send_segment(6'd3, 100, 0, 0, '0);
    send_segment(6'd5, 4, 0, 0, '0);

    // Tempo change mid-run keeps the run, Q becomes 32
    send_segment(6'd7, 50, 0, 0, '0);
    set_bpm(8'd120);
    send_segment(6'd7, 50, 0, 0, '0);
    send_segment(6'd2, 4, 0, 0, '0);

    // bpm 0 treated as 1: huge Q, nothing classifies
    set_bpm(8'd0);
    send_segment(6'd1, 100, 0, 0, '0);
    send_segment(6'd2, 4, 0, 0, '0);
    set_bpm(8'd60);

    // Randomized runs, bursts, tempos and consumer stalls
    rnd_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k % 5 == 4) begin
        nb = bpms[$urandom_range(0, 3)];
        if (nb != bpm_in) set_bpm(nb);
      end
      t = 6'($urandom_range(0, 7));
      n = $urandom_range(GL, 300);
      blen = 0; bpos = 0; bt = '0;
      if (n >= 12 && $urandom_range(0, 2) == 0) begin
        blen = $urandom_range(1, GL - 1);
        bpos = $urandom_range(GL, n - 1 - blen);
        bt   = t ^ 6'($urandom_range(1, 7));
      end
      send_segment(t, n, bpos, blen, bt);
    end
    rnd_ready = 1'b0;
    event_ready_in = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, tone_in);
    chk("final_drain", {31'd0, event_valid_out}, 32'd0);

    // Reset mid-run clears everything including sticky overflow
    send_segment(6'd3, 30, 0, 0, '0);
    do_reset(8'd60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
